// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, status flags, barrel shifts,
// signed/unsigned compare and an iterative shift-add unsigned multiplier.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; inputs are sampled only then, outputs hold until theirs.
  state_t                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       y_q, y_d, hi_q, hi_d;
  logic                   zero_q, zero_d, carry_q, carry_d;
  logic                   ovf_q, ovf_d, ill_q, ill_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [SHW-1:0]         cnt_q, cnt_d;

  logic                   accept, is_mul;
  logic [SHW-1:0]         sh;
  logic [WIDTH:0]         add_w, sub_w, mul_sum;
  logic [2*WIDTH-1:0]     mul_step;
  logic [WIDTH-1:0]       res_y;
  logic                   res_c, res_v, res_ill;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == 4'd11) && MUL_EN;
  assign sh       = b[SHW-1:0];
  assign add_w    = {1'b0, a} + {1'b0, b};
  assign sub_w    = {1'b0, a} - {1'b0, b};

  // One shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc_q[0]) is set, then shift right keeping the carry.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (op)
      4'd0: begin
        res_y = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        res_y = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  res_y = a & b;
      4'd3:  res_y = a | b;
      4'd4:  res_y = a ^ b;
      4'd5:  res_y = ~(a | b);
      4'd6:  res_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd7:  res_y = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd8:  res_y = a << sh;
      4'd9:  res_y = a >> sh;
      4'd10: res_y = $signed(a) >>> sh;
      4'd11: res_ill = !MUL_EN;
      default: res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept && is_mul) begin
          state_d     = S_MUL;
          acc_d       = {{WIDTH{1'b0}}, b};
          mcand_d     = a;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end else if (accept) begin
          y_d         = res_y;
          hi_d        = '0;
          zero_d      = (res_y == '0);
          carry_d     = res_c;
          ovf_d       = res_v;
          ill_d       = res_ill;
          out_valid_d = 1'b1;
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          y_d         = mul_step[WIDTH-1:0];
          hi_d        = mul_step[2*WIDTH-1:WIDTH];
          zero_d      = (mul_step == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign y           = y_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign ovf         = ovf_q;
  assign illegal     = ill_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq: expected results are queued at accept
// and compared field by field when the output handshake completes.
module tb_alu_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         illegal;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y, hi;
  logic         zero, carry, ovf, illegal;
  logic [1:0]   dbg_state;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .hi(hi), .zero(zero), .carry(carry), .ovf(ovf),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic res_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    res_t        r;
    logic [W:0]  s;
    logic [63:0] p;
    logic [4:0]  n;
    r = '0;
    n = z[4:0];
    case (o)
      4'd0: begin
        s = {1'b0, x} + {1'b0, z};
        r.y = s[W-1:0];
        r.carry = s[W];
        r.ovf = (x[W-1] == z[W-1]) && (r.y[W-1] != x[W-1]);
      end
      4'd1: begin
        r.y = x - z;
        r.carry = (x < z);
        r.ovf = (x[W-1] != z[W-1]) && (r.y[W-1] != x[W-1]);
      end
      4'd2:  r.y = x & z;
      4'd3:  r.y = x | z;
      4'd4:  r.y = x ^ z;
      4'd5:  r.y = ~(x | z);
      4'd6:  r.y = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      4'd7:  r.y = (x < z) ? 32'd1 : 32'd0;
      4'd8:  r.y = x << n;
      4'd9:  r.y = x >> n;
      4'd10: r.y = $signed(x) >>> n;
      4'd11: begin
        p = {32'd0, x} * {32'd0, z};
        r.hi = p[63:32];
        r.y = p[31:0];
      end
      default: r.illegal = 1'b1;
    endcase
    r.zero = ({r.hi, r.y} == 64'd0);
    return r;
  endfunction

  // scoreboard: compare on every output transfer, away from the active edge
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("y", {32'd0, y}, {32'd0, e.y});
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("zero", {63'd0, zero}, {63'd0, e.zero});
        chk("carry", {63'd0, carry}, {63'd0, e.carry});
        chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
        chk("illegal", {63'd0, illegal}, {63'd0, e.illegal});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    int n;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = z;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      exp_q.push_back(model(o, x, z));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
    tick();
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", {32'd0, y}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_flags", {61'd0, carry, ovf, illegal}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    out_ready = 1'b1;
    tick();

    // arithmetic, compare and shift corner cases
    send(4'd0, 32'h7FFFFFFF, 32'h1);
    chk("add_ovf_lat1", {63'd0, out_valid}, 64'd1);
    chk("add_ovf_y", {32'd0, y}, 64'h80000000);
    chk("add_ovf_flag", {62'd0, ovf, carry}, 64'd2);
    send(4'd0, 32'hFFFFFFFF, 32'h1);
    chk("add_carry", {61'd0, carry, zero, ovf}, 64'd6);
    send(4'd1, 32'd5, 32'd5);
    send(4'd1, 32'd0, 32'd1);
    chk("sub_borrow_y", {32'd0, y}, 64'hFFFFFFFF);
    send(4'd1, 32'h80000000, 32'd1);
    chk("sub_ovf", {63'd0, ovf}, 64'd1);
    send(4'd6, 32'hFFFFFFFF, 32'd1);
    send(4'd7, 32'hFFFFFFFF, 32'd1);
    send(4'd10, 32'h80000000, 32'd4);
    chk("sra_y", {32'd0, y}, 64'hF8000000);
    send(4'd9, 32'h80000000, 32'd4);
    send(4'd8, 32'd1, 32'h25);
    chk("sll_y", {32'd0, y}, 64'h20);
    send(4'd8, 32'hA5A5A5A5, 32'h20);
    send(4'd2, 32'hF0F0, 32'hFF00);
    send(4'd3, 32'hF0F0, 32'hFF00);
    send(4'd4, 32'hF0F0, 32'hFF00);
    send(4'd5, 32'hF0F0, 32'hFF00);
    drain();

    // multiply latency, busy window and operand isolation
    send(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_state", {62'd0, dbg_state}, 64'd1);
    for (int i = 1; i <= W; i++) begin
      chk("mul_busy_ready", {63'd0, in_ready}, 64'd0);
      chk("mul_busy_valid", {63'd0, out_valid}, 64'd0);
      a = $urandom;
      b = $urandom;
      op = 4'($urandom_range(0, 15));
      tick();
    end
    chk("mul_done_valid", {63'd0, out_valid}, 64'd1);
    chk("mul_hi", {32'd0, hi}, 64'hFFFFFFFE);
    chk("mul_lo", {32'd0, y}, 64'h1);
    drain();
    send(4'd11, 32'd0, 32'h12345678);
    send(4'd11, 32'h0001_0000, 32'h0003_0000);
    drain();

    // output stall, then simultaneous output and input transfers
    out_ready = 1'b0;
    send(4'd0, 32'h10, 32'h20);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_y", {32'd0, y}, 64'h30);
      chk("hold_flags", {61'd0, zero, carry, ovf}, 64'd0);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    send(4'd2, 32'hF0F0, 32'hFF00);
    chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_y", {32'd0, y}, 64'hF000);
    drain();

    // random ops with occasional consumer stalls
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
      end
      send(ro, ra, rb);
    end
    drain();

    // reset in the middle of a multiply
    send(4'd11, 32'd3, 32'd5);
    repeat (9) tick();
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_y", {32'd0, y}, 64'd0);
    chk("mid_rst_zero", {63'd0, zero}, 64'd1);
    chk("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    send(4'd0, 32'd2, 32'd3);
    chk("post_rst_add", {32'd0, y}, 64'd5);
    send(4'd13, 32'h1234, 32'h5678);
    chk("illegal_flags", {61'd0, illegal, zero, carry}, 64'd6);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. It has a valid/ready handshake on both sides, status flags, barrel shifts by a variable amount, signed and unsigned compare, and an iterative unsigned multiplier with a double-width result. It sits in the multi-cycle MIPS execute stage, between the operand registers and the ALUOut/HI/LO registers.

Parameters:
WIDTH, 32, operand and result width in bits (≥ 4, power of 2)
MUL_EN, 1, 1 enables MULU (op 11); 0 makes op 11 illegal
SHW (localparam), $clog2(WIDTH), shift-amount width taken from b[SHW-1:0]

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept; transfer when in_valid && in_ready
op  in  4  operation code
a  in  WIDTH  operand A (shift source)
b  in  WIDTH  operand B (shift amount in b[SHW-1:0])
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes result; transfer when out_valid && out_ready
y  out  WIDTH  result, or low half of product
hi  out  WIDTH  high half of product; 0 for non-MUL ops
zero  out  1  result == 0 (MULU: {hi,y} == 0)
carry  out  1  ADD carry-out; SUB borrow (a < b unsigned); 0 otherwise
ovf  out  1  signed overflow for ADD/SUB; 0 otherwise
illegal  out  1  op unsupported; y = 0, hi = 0, zero = 1

Behaviour:
- Reset (reset = 0, asynchronous) forces: state IDLE; out_valid, y, hi, carry, ovf and illegal to 0; zero to 1; multiplier counter and accumulator cleared. in_ready = 1 as soon as reset deasserts. Reset mid-MULU aborts it with no output.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed compare, y = 0 or 1), 7 SLTU (unsigned compare)
  - 8 SLL, 9 SRL, 10 SRA (shift a by b[SHW-1:0])
  - 11 MULU (unsigned a*b)
  - 12-15 illegal
- Arithmetic is modulo 2^WIDTH. ADD and SUB are computed WIDTH+1 wide to produce carry/borrow.
  - ovf for ADD = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]).
  - ovf for SUB = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]).
- State machine: IDLE, MUL, HOLD.
  - in_ready = (state == IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops are therefore accepted every cycle while out_ready = 1.
  - Single-cycle op accepted at edge N: result and flags are registered at edge N; out_valid = 1 from edge N. Latency is 1 cycle.
  - MULU accepted at edge N: a and b are latched, state goes to MUL, and out_valid drops (if the previous result was consumed).
    - Shift-add runs one bit per cycle for exactly WIDTH cycles.
    - At edge N+WIDTH, {hi,y} holds the product, zero is set, and out_valid = 1.
    - state = MUL implies in_ready = 0.
  - With out_valid = 1 and out_ready = 0, the state is HOLD (or IDLE with in_ready = 0). y, hi, flags and out_valid stay stable until the transfer.
  - At the edge where the output transfers: if a new op is also accepted, its result replaces the old one with out_valid kept at 1. Otherwise out_valid goes to 0.
- Operand and op inputs are sampled only on the accepting edge. Changes while in MUL/HOLD are ignored.
- With MUL_EN = 0, op 11 behaves like ops 12-15: a 1-cycle result with illegal = 1.
- Shift amount 0 returns a unchanged. Shift amounts ≥ WIDTH cannot occur because only SHW bits are used.

Test Plan (WIDTH = 32):
- ADD a=0x7FFFFFFF, b=1 → one cycle after accept: y=0x80000000, ovf=1, carry=0, zero=0. Then ADD 0xFFFFFFFF+1 → y=0, carry=1, zero=1, ovf=0.
- SUB 5-5 → y=0, zero=1, carry=0. SUB 0-1 → y=0xFFFFFFFF, carry=1, ovf=0. SUB 0x80000000-1 → y=0x7FFFFFFF, ovf=1.
- SLT a=0xFFFFFFFF, b=1 → y=1. SLTU with the same operands → y=0. SRA a=0x80000000, b=4 → y=0xF8000000. SRL with the same operands → 0x08000000. SLL a=1, b=0x25 → y=0x20 (b[4:0] = 5).
- MULU 0xFFFFFFFF × 0xFFFFFFFF → in_ready=0 for cycles 1-32 after accept; at edge 32: hi=0xFFFFFFFE, y=0x00000001, out_valid=1. Changing a/b mid-multiply must not alter the result.
- Hold out_ready=0 for 5 cycles after an ADD result → y and flags stable, in_ready=0. Raise out_ready with in_valid=1 (AND 0xF0F0 & 0xFF00) → both transfers occur on the same edge; next y=0xF000.
- Assert reset at cycle 10 of a MULU → out_valid=0, y=0, zero=1 immediately. After deassert, in_ready=1 and ADD 2+3 gives y=5. Op 13 → y=0, illegal=1, zero=1.
